// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and saturating stall/flush performance counters.
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              ex_flush,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              hz_loaduse,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int CTRL_MEMREAD = 1;

    logic [XLEN-1:0]   ex_pc_reg;
    logic [XLEN-1:0]   ex_rs1_data_reg;
    logic [XLEN-1:0]   ex_rs2_data_reg;
    logic [XLEN-1:0]   ex_imm_reg;
    logic [4:0]        ex_rs1_reg;
    logic [4:0]        ex_rs2_reg;
    logic [4:0]        ex_rd_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic              ex_valid_reg;

    logic              rs1_match;
    logic              rs2_match;
    logic              load_in_ex;
    logic              stall_req;
    logic              bubble;

    // Hazard is judged only against what is already registered in EX.
    assign load_in_ex = ex_valid_reg & ex_ctrl_reg[CTRL_MEMREAD] & (ex_rd_reg != 5'd0);
    assign rs1_match  = id_use_rs1 & (id_rs1 == ex_rd_reg);
    assign rs2_match  = id_use_rs2 & (id_rs2 == ex_rd_reg);
    assign hz_loaduse = load_in_ex & (rs1_match | rs2_match);

    // A flush overrides the stall, so front-end enables only drop for a true stall.
    assign stall_req  = hz_loaduse & ~ex_flush;
    assign pc_write   = ~hold & ~stall_req;
    assign ifid_write = ~hold & ~stall_req;
    assign bubble     = ex_flush | hz_loaduse;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_pc_reg       <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_rd_reg       <= '0;
            ex_ctrl_reg     <= '0;
            ex_valid_reg    <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                ex_pc_reg       <= '0;
                ex_rs1_data_reg <= '0;
                ex_rs2_data_reg <= '0;
                ex_imm_reg      <= '0;
                ex_rs1_reg      <= '0;
                ex_rs2_reg      <= '0;
                ex_rd_reg       <= '0;
                ex_ctrl_reg     <= '0;
                ex_valid_reg    <= 1'b0;
            end else begin
                ex_pc_reg       <= id_pc;
                ex_rs1_data_reg <= id_rs1_data;
                ex_rs2_data_reg <= id_rs2_data;
                ex_imm_reg      <= id_imm;
                ex_rs1_reg      <= id_rs1;
                ex_rs2_reg      <= id_rs2;
                ex_rd_reg       <= id_rd;
                ex_ctrl_reg     <= id_ctrl;
                ex_valid_reg    <= 1'b1;
            end
        end
    end

    // Counter 0 tracks load-use bubbles, counter 1 tracks flushes.
    logic [CNT_W-1:0] cnt_reg [2];
    logic [1:0]       cnt_inc;

    assign cnt_inc[0] = ~hold & stall_req;
    assign cnt_inc[1] = ~hold & ex_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign ex_pc       = ex_pc_reg;
    assign ex_rs1_data = ex_rs1_data_reg;
    assign ex_rs2_data = ex_rs2_data_reg;
    assign ex_imm      = ex_imm_reg;
    assign ex_rs1      = ex_rs1_reg;
    assign ex_rs2      = ex_rs2_reg;
    assign ex_rd       = ex_rd_reg;
    assign ex_ctrl     = ex_ctrl_reg;
    assign ex_valid    = ex_valid_reg;
    assign stall_cnt   = cnt_reg[0];
    assign flush_cnt   = cnt_reg[1];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed-vector bench for id_ex_stage_reg; a narrow-counter copy shares the
// stimulus so counter saturation is reached within a short run.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset, hold, ex_flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [7:0]  id_ctrl;

    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic        ex_valid, pc_write, ifid_write, hz_loaduse;
    logic [31:0] stall_cnt, flush_cnt;

    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [7:0]  s_ctrl;
    logic        s_valid, s_pc_write, s_ifid_write, s_hz;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .ex_flush(ex_flush),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .pc_write(pc_write),
        .ifid_write(ifid_write), .hz_loaduse(hz_loaduse),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold), .ex_flush(ex_flush),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl),
        .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data),
        .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .ex_ctrl(s_ctrl), .ex_valid(s_valid), .pc_write(s_pc_write),
        .ifid_write(s_ifid_write), .hz_loaduse(s_hz),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic        hold, flush;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [7:0]  ctrl;
        logic        e_hz, e_pcw, e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [7:0]  e_ctrl;
        int          e_sc, e_fc;
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(logic h, logic f, logic [31:0] pc, logic [4:0] rs1,
                                logic [4:0] rs2, logic [4:0] rd, logic u1, logic u2,
                                logic [7:0] ctrl, logic ehz, logic epcw, logic ev,
                                logic [31:0] epc, logic [4:0] ers1, logic [4:0] ers2,
                                logic [4:0] erd, logic [7:0] ectrl, int esc, int efc);
        vec_t v;
        v.hold = h; v.flush = f; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.ctrl = ctrl; v.e_hz = ehz; v.e_pcw = epcw;
        v.e_valid = ev; v.e_pc = epc; v.e_rs1 = ers1; v.e_rs2 = ers2; v.e_rd = erd;
        v.e_ctrl = ectrl; v.e_sc = esc; v.e_fc = efc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic f, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [7:0] ctrl);
        hold = h; ex_flush = f; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_ctrl = ctrl;
        id_rs1_data = pc + 32'h1000;
        id_rs2_data = pc + 32'h2000;
        id_imm      = pc + 32'h3000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 64'(ex_valid), 64'd0);
        chk({tag, ".ctrl"}, 64'(ex_ctrl), 64'd0);
        chk({tag, ".pc"}, 64'(ex_pc), 64'd0);
        chk({tag, ".rd"}, 64'(ex_rd), 64'd0);
        chk({tag, ".rs1"}, 64'(ex_rs1), 64'd0);
        chk({tag, ".rs2"}, 64'(ex_rs2), 64'd0);
        chk({tag, ".data"}, 64'(ex_rs1_data | ex_rs2_data | ex_imm), 64'd0);
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(0,0,'h100, 1, 2, 5,1,1,'h01, 0,1,1,'h100, 1, 2, 5,'h01,0,0);
        vecs[1]  = mk(0,0,'h104, 2, 0, 5,1,0,'h1B, 0,1,1,'h104, 2, 0, 5,'h1B,0,0);
        vecs[2]  = mk(0,0,'h108, 5, 3, 6,1,1,'h01, 1,0,0,'h000, 0, 0, 0,'h00,1,0);
        vecs[3]  = mk(0,0,'h108, 5, 3, 6,1,1,'h01, 0,1,1,'h108, 5, 3, 6,'h01,1,0);
        vecs[4]  = mk(0,0,'h10C, 1, 0, 0,1,0,'h1B, 0,1,1,'h10C, 1, 0, 0,'h1B,1,0);
        vecs[5]  = mk(0,0,'h110, 0, 0, 8,1,0,'h01, 0,1,1,'h110, 0, 0, 8,'h01,1,0);
        vecs[6]  = mk(0,0,'h114, 1, 0, 7,1,0,'h1B, 0,1,1,'h114, 1, 0, 7,'h1B,1,0);
        vecs[7]  = mk(0,0,'h118, 2, 7, 9,1,0,'h01, 0,1,1,'h118, 2, 7, 9,'h01,1,0);
        vecs[8]  = mk(0,0,'h11C, 1, 0, 7,1,0,'h1B, 0,1,1,'h11C, 1, 0, 7,'h1B,1,0);
        vecs[9]  = mk(0,1,'h120, 7, 0,10,1,0,'h01, 1,1,0,'h000, 0, 0, 0,'h00,1,1);
        vecs[10] = mk(0,0,'h124, 1, 0,11,1,0,'h1B, 0,1,1,'h124, 1, 0,11,'h1B,1,1);
        vecs[11] = mk(0,0,'h128,11, 0,12,1,0,'h1B, 1,0,0,'h000, 0, 0, 0,'h00,2,1);
        vecs[12] = mk(0,0,'h128,11, 0,12,1,0,'h1B, 0,1,1,'h128,11, 0,12,'h1B,2,1);
        vecs[13] = mk(0,0,'h12C, 1,12,13,1,1,'h01, 1,0,0,'h000, 0, 0, 0,'h00,3,1);
        vecs[14] = mk(0,0,'h12C, 1,12,13,1,1,'h01, 0,1,1,'h12C, 1,12,13,'h01,3,1);
        vecs[15] = mk(0,0,'h130, 1, 0,14,1,0,'h1B, 0,1,1,'h130, 1, 0,14,'h1B,3,1);
        vecs[16] = mk(1,1,'h134,14, 0,15,1,0,'h01, 1,0,1,'h130, 1, 0,14,'h1B,3,1);
        vecs[17] = mk(1,1,'h134,14, 0,15,1,0,'h01, 1,0,1,'h130, 1, 0,14,'h1B,3,1);
        vecs[18] = mk(1,1,'h134,14, 0,15,1,0,'h01, 1,0,1,'h130, 1, 0,14,'h1B,3,1);
        vecs[19] = mk(0,1,'h134,14, 0,15,1,0,'h01, 1,1,0,'h000, 0, 0, 0,'h00,3,2);
        vecs[20] = mk(0,0,'h134,14, 0,15,1,0,'h01, 0,1,1,'h134,14, 0,15,'h01,3,2);
        vecs[21] = mk(0,0,'h138, 1, 0,16,1,0,'h1B, 0,1,1,'h138, 1, 0,16,'h1B,3,2);
        vecs[22] = mk(0,0,'h13C,16, 0,17,1,0,'h01, 1,0,0,'h000, 0, 0, 0,'h00,4,2);
        vecs[23] = mk(0,0,'h13C,16, 0,17,1,0,'h01, 0,1,1,'h13C,16, 0,17,'h01,4,2);
        vecs[24] = mk(0,1,'h140, 1, 0,18,1,0,'h01, 0,1,0,'h000, 0, 0, 0,'h00,4,3);
        vecs[25] = mk(0,1,'h140, 1, 0,18,1,0,'h01, 0,1,0,'h000, 0, 0, 0,'h00,4,4);
        vecs[26] = mk(0,0,'h144, 1, 0,18,1,0,'h80, 0,1,1,'h144, 1, 0,18,'h80,4,4);

        reset = 1'b1;
        drive(0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 8'h00);
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            vec_t v;
            logic [31:0] e_d1, e_d2, e_im;
            v = vecs[i];
            drive(v.hold, v.flush, v.pc, v.rs1, v.rs2, v.rd, v.u1, v.u2, v.ctrl);
            #1;
            chk($sformatf("v%0d.hz_loaduse", i), 64'(hz_loaduse), 64'(v.e_hz));
            chk($sformatf("v%0d.pc_write", i), 64'(pc_write), 64'(v.e_pcw));
            chk($sformatf("v%0d.ifid_write", i), 64'(ifid_write), 64'(v.e_pcw));
            step();
            e_d1 = v.e_valid ? v.e_pc + 32'h1000 : 32'h0;
            e_d2 = v.e_valid ? v.e_pc + 32'h2000 : 32'h0;
            e_im = v.e_valid ? v.e_pc + 32'h3000 : 32'h0;
            chk($sformatf("v%0d.ex_valid", i), 64'(ex_valid), 64'(v.e_valid));
            chk($sformatf("v%0d.ex_pc", i), 64'(ex_pc), 64'(v.e_pc));
            chk($sformatf("v%0d.ex_rs1", i), 64'(ex_rs1), 64'(v.e_rs1));
            chk($sformatf("v%0d.ex_rs2", i), 64'(ex_rs2), 64'(v.e_rs2));
            chk($sformatf("v%0d.ex_rd", i), 64'(ex_rd), 64'(v.e_rd));
            chk($sformatf("v%0d.ex_ctrl", i), 64'(ex_ctrl), 64'(v.e_ctrl));
            chk($sformatf("v%0d.ex_rs1_data", i), 64'(ex_rs1_data), 64'(e_d1));
            chk($sformatf("v%0d.ex_rs2_data", i), 64'(ex_rs2_data), 64'(e_d2));
            chk($sformatf("v%0d.ex_imm", i), 64'(ex_imm), 64'(e_im));
            chk($sformatf("v%0d.stall_cnt", i), 64'(stall_cnt), 64'(v.e_sc));
            chk($sformatf("v%0d.flush_cnt", i), 64'(flush_cnt), 64'(v.e_fc));
            chk($sformatf("v%0d.sat_stall_cnt", i), 64'(s_stall_cnt),
                64'((v.e_sc > 3) ? 3 : v.e_sc));
            chk($sformatf("v%0d.sat_flush_cnt", i), 64'(s_flush_cnt),
                64'((v.e_fc > 3) ? 3 : v.e_fc));
            $display("vec %0d: hz=%0b pcw=%0b valid=%0b pc=%0h rd=%0d ctrl=%0h stall=%0d flush=%0d",
                     i, v.e_hz, v.e_pcw, ex_valid, ex_pc, ex_rd, ex_ctrl, stall_cnt, flush_cnt);
        end

        // Reset arriving while a load-use hazard is active must win outright.
        drive(0, 0, 32'h148, 5'd1, 5'd0, 5'd20, 1, 0, 8'h1B);
        step();
        drive(0, 0, 32'h14C, 5'd20, 5'd0, 5'd21, 1, 0, 8'h01);
        #1;
        chk("rst_mid.hz_before", 64'(hz_loaduse), 64'd1);
        chk("rst_mid.pcw_before", 64'(pc_write), 64'd0);
        reset = 1'b1;
        step();
        chk_all_zero("rst_mid");
        chk("rst_mid.hz_after", 64'(hz_loaduse), 64'd0);
        chk("rst_mid.sat_stall", 64'(s_stall_cnt), 64'd0);
        $display("reset mid-stall: valid=%0b stall=%0d flush=%0d", ex_valid, stall_cnt, flush_cnt);
        reset = 1'b0;
        step();
        chk("post_rst.valid", 64'(ex_valid), 64'd1);
        chk("post_rst.pc", 64'(ex_pc), 64'h14C);
        chk("post_rst.rs1", 64'(ex_rs1), 64'd20);
        chk("post_rst.stall_cnt", 64'(stall_cnt), 64'd0);
        $display("post reset capture: valid=%0b pc=%0h rs1=%0d", ex_valid, ex_pc, ex_rs1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection. It sits directly upstream of the EX-stage forwarding unit.
- It latches decoded operands, register indices and control from ID. It inserts one-cycle bubbles on load-use hazards, applies branch/jump flushes and honours a global pipeline hold.
- Its registered rs1/rs2/rd/ctrl outputs feed the forwarding unit and the EX datapath. It also keeps saturating stall/flush counters for performance reporting.

Parameters:
- XLEN, 32, width of PC, operand data and immediate.
- CTRL_W, 8, width of control bundle. Bit map: [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg, [4] alusrc, [5] branch, [6] jump, [7] reserved (carried through unchanged).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  global pipeline freeze, e.g. data-memory busy.
- ex_flush  input  1  branch/jump taken, resolved in EX this cycle.
- id_pc  input  XLEN  PC of instruction in ID.
- id_rs1, id_rs2, id_rd  input  5 each  decoded register indices.
- id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data  input  XLEN each  register file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_ctrl  input  CTRL_W  decoded control bundle.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered to EX.
- ex_rs1, ex_rs2, ex_rd  output  5 each  registered to EX and the forwarding unit.
- ex_ctrl  output  CTRL_W  registered control bundle.
- ex_valid  output  1  EX holds a real instruction (0 = bubble).
- pc_write  output  1  PC register enable (combinational).
- ifid_write  output  1  IF/ID register enable (combinational).
- hz_loaduse  output  1  load-use hazard detected this cycle (combinational).
- stall_cnt  output  CNT_W  count of load-use bubbles inserted.
- flush_cnt  output  CNT_W  count of flush cycles applied.

Behaviour:
- Reset:
  - All ex_* outputs are 0, including ex_valid=0 and ex_ctrl=0.
  - stall_cnt=0 and flush_cnt=0.
  - Reset has priority over all other inputs.
- Hazard detect (combinational from current registered state):
  - hz_loaduse = ex_valid & ex_ctrl[1] & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Per-edge update, priority highest first:
  1. reset: clear as above.
  2. hold=1: every register, including counters, keeps its value. ex_flush and hz_loaduse are ignored and take effect on the first edge after hold deasserts, because EX does not advance.
  3. ex_flush=1: bubble is loaded (ex_ctrl=0, ex_valid=0, ex_rd=0, ex_rs1=0, ex_rs2=0; data fields may be don't-care but are driven to 0). flush_cnt increments. Flush wins over a simultaneous hz_loaduse, and stall_cnt does not increment.
  4. hz_loaduse=1: bubble is loaded as in item 3. stall_cnt increments.
  5. Otherwise: all id_* values are captured and ex_valid=1.
- pc_write and ifid_write:
  - Both = ~hold & ~(hz_loaduse & ~ex_flush).
  - On flush they stay 1; the IF/ID flush itself is handled by the IF/ID register.
- Stall length:
  - A load-use bubble lasts exactly one cycle. After the bubble, ex_ctrl[1]=0, so the hazard clears and the stalled ID instruction is captured on the next edge.
  - Back-to-back loads each produce exactly one bubble.
- Counters: saturate at all-ones and do not wrap.
- Index 0: an x0 destination never triggers a hazard.
- Latency: one cycle from id_* to ex_*. There are no combinational paths from id_* to ex_* outputs.

Test Plan:
- Normal capture: reset 2 cycles, then id_pc=0x100, id_rd=5, id_ctrl=0x01 -> next edge ex_pc=0x100, ex_rd=5, ex_ctrl=0x01, ex_valid=1, pc_write=1, ifid_write=1.
- Load-use:
  - Load lw x5 enters EX (ex_ctrl[1]=1, ex_rd=5); ID holds add with id_rs1=5, id_use_rs1=1.
  - Expect hz_loaduse=1, pc_write=0, ifid_write=0.
  - Next edge: ex_valid=0, ex_ctrl=0, stall_cnt=1.
  - Following edge: add captured with ex_rs1=5, ex_valid=1.
- x0 and unused source:
  - Load with ex_rd=0 and id_rs1=0 -> hz_loaduse=0.
  - Load with ex_rd=7, id_rs2=7, id_use_rs2=0 -> hz_loaduse=0.
- Flush vs stall: ex_flush=1 with hz_loaduse=1 on the same cycle -> bubble loaded, flush_cnt=1, stall_cnt=0, pc_write=1.
- Hold: assert hold 3 cycles during a pending ex_flush -> ex_* and counters unchanged, pc_write=0. On release, flush is applied on the first edge, flush_cnt=1.
- Saturation and reset mid-stall:
  - Force stall_cnt to 0xFFFFFFFF, then trigger a load-use -> stall_cnt stays 0xFFFFFFFF.
  - Assert reset during hz_loaduse -> all outputs 0 next edge and no counter increment.
